// File: rtl/rx_ctrl_seq_decoder_if.sv
// Line-level inputs and decoded control outputs of rx_ctrl_seq_decoder.
// The err_cnt bus exists only when RX_CTRL_ERR_CNT_EN is defined.
interface rx_ctrl_seq_decoder_if #(
    parameter int NUM_TRIOS = 1
);
    logic [NUM_TRIOS-1:0]   A;
    logic [NUM_TRIOS-1:0]   B;
    logic [NUM_TRIOS-1:0]   C;
    logic                   dec_en;
    logic [2*NUM_TRIOS-1:0] ctrl_state;
    logic [NUM_TRIOS-1:0]   ctrl_valid;
    logic [NUM_TRIOS-1:0]   hs_entry;
    logic [NUM_TRIOS-1:0]   esc_entry;
    logic [NUM_TRIOS-1:0]   seq_err;
`ifdef RX_CTRL_ERR_CNT_EN
    logic [8*NUM_TRIOS-1:0] err_cnt;

    modport master (
        output A, B, C, dec_en,
        input  ctrl_state, ctrl_valid, hs_entry, esc_entry, seq_err, err_cnt
    );
    modport slave (
        input  A, B, C, dec_en,
        output ctrl_state, ctrl_valid, hs_entry, esc_entry, seq_err, err_cnt
    );
`else
    modport master (
        output A, B, C, dec_en,
        input  ctrl_state, ctrl_valid, hs_entry, esc_entry, seq_err
    );
    modport slave (
        input  A, B, C, dec_en,
        output ctrl_state, ctrl_valid, hs_entry, esc_entry, seq_err
    );
`endif
endinterface

// File: rtl/rx_ctrl_seq_decoder.sv
// Per-trio LP line-state glitch filter plus HS/escape entry sequence FSM.
// Optional per-trio saturating error counter enabled by RX_CTRL_ERR_CNT_EN.
module rx_ctrl_seq_decoder #(
    parameter int NUM_TRIOS     = 1,
    parameter int FILTER_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rx_ctrl_seq_decoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, STOP, HSRQ, LPRQ} fsm_e;

    localparam logic [3:0] FILT        = 4'(FILTER_CYCLES);
    localparam logic [1:0] CODE_STOP   = 2'b00;
    localparam logic [1:0] CODE_HSRQ   = 2'b01;
    localparam logic [1:0] CODE_BRIDGE = 2'b10;
    localparam logic [1:0] CODE_LPRQ   = 2'b11;

    for (genvar i = 0; i < NUM_TRIOS; i++) begin : g_trio
        logic [2:0] sample;
        logic [2:0] prevSample_q;
        logic [3:0] stableCnt_q, stableCnt_d;
        fsm_e       state_q, state_d;
        logic [1:0] ctrlState_q, ctrlState_d;
        logic       ctrlValid_q, ctrlValid_d;
        logic       hsEntry_q, hsEntry_d;
        logic       escEntry_q, escEntry_d;
        logic       seqErr_q, seqErr_d;
        logic       accept, legal, newCode;
        logic [1:0] code;
`ifdef RX_CTRL_ERR_CNT_EN
        logic [7:0] errCnt_q;
`endif

        assign sample = {bus.A[i], bus.B[i], bus.C[i]};

        // A still-saturated counter on an unchanged sample means the state was already accepted.
        always_comb begin
            legal = 1'b1;
            code  = CODE_STOP;
            case (sample)
                3'b111:  code  = CODE_STOP;
                3'b001:  code  = CODE_HSRQ;
                3'b000:  code  = CODE_BRIDGE;
                3'b100:  code  = CODE_LPRQ;
                default: legal = 1'b0;
            endcase

            if (sample == prevSample_q) begin
                stableCnt_d = (stableCnt_q >= FILT) ? FILT : stableCnt_q + 4'd1;
            end else begin
                stableCnt_d = 4'd1;
            end
            accept  = (stableCnt_d == FILT) &&
                      ((stableCnt_q != FILT) || (sample != prevSample_q));
            newCode = accept && legal && (!ctrlValid_q || (code != ctrlState_q));

            state_d     = state_q;
            ctrlState_d = ctrlState_q;
            ctrlValid_d = ctrlValid_q;
            hsEntry_d   = 1'b0;
            escEntry_d  = 1'b0;
            seqErr_d    = 1'b0;

            if (accept && !legal) begin
                ctrlValid_d = 1'b0;
                if (state_q != IDLE) begin
                    seqErr_d = 1'b1;
                    state_d  = IDLE;
                end
            end else if (accept) begin
                ctrlState_d = code;
                ctrlValid_d = 1'b1;
            end

            if (newCode) begin
                case (state_q)
                    IDLE: begin
                        if (code == CODE_STOP) state_d = STOP;
                    end
                    STOP: begin
                        case (code)
                            CODE_HSRQ:   state_d = HSRQ;
                            CODE_LPRQ:   state_d = LPRQ;
                            CODE_BRIDGE: begin state_d = IDLE; seqErr_d = 1'b1; end
                            default:     state_d = STOP;
                        endcase
                    end
                    // Returning to STOP from a request is a clean abort, not an error.
                    HSRQ: begin
                        case (code)
                            CODE_BRIDGE: begin state_d = IDLE; hsEntry_d = 1'b1; end
                            CODE_STOP:   state_d = STOP;
                            CODE_LPRQ:   begin state_d = IDLE; seqErr_d = 1'b1; end
                            default:     state_d = HSRQ;
                        endcase
                    end
                    LPRQ: begin
                        case (code)
                            CODE_BRIDGE: begin state_d = IDLE; escEntry_d = 1'b1; end
                            CODE_STOP:   state_d = STOP;
                            CODE_HSRQ:   begin state_d = IDLE; seqErr_d = 1'b1; end
                            default:     state_d = LPRQ;
                        endcase
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        // Disable clears everything that reset clears except the error tally.
        always_ff @(posedge clk) begin
            if (rst || !bus.dec_en) begin
                prevSample_q <= 3'b000;
                stableCnt_q  <= 4'd0;
                state_q      <= IDLE;
                ctrlState_q  <= 2'b00;
                ctrlValid_q  <= 1'b0;
                hsEntry_q    <= 1'b0;
                escEntry_q   <= 1'b0;
                seqErr_q     <= 1'b0;
`ifdef RX_CTRL_ERR_CNT_EN
                if (rst) errCnt_q <= 8'd0;
`endif
            end else begin
                prevSample_q <= sample;
                stableCnt_q  <= stableCnt_d;
                state_q      <= state_d;
                ctrlState_q  <= ctrlState_d;
                ctrlValid_q  <= ctrlValid_d;
                hsEntry_q    <= hsEntry_d;
                escEntry_q   <= escEntry_d;
                seqErr_q     <= seqErr_d;
`ifdef RX_CTRL_ERR_CNT_EN
                if (seqErr_d && (errCnt_q != 8'hFF)) errCnt_q <= errCnt_q + 8'd1;
`endif
            end
        end

        assign bus.ctrl_state[2*i +: 2] = ctrlState_q;
        assign bus.ctrl_valid[i]        = ctrlValid_q;
        assign bus.hs_entry[i]          = hsEntry_q;
        assign bus.esc_entry[i]         = escEntry_q;
        assign bus.seq_err[i]           = seqErr_q;
`ifdef RX_CTRL_ERR_CNT_EN
        assign bus.err_cnt[8*i +: 8]    = errCnt_q;
`endif
    end
endmodule

// File: doc/rx_ctrl_seq_decoder.md
RX_CTRL_SEQ_DECODER -- requirements
Module: rx_ctrl_seq_decoder

Interface
REQ-001 Parameter: NUM_TRIOS, default 1, number of independent trios (1..4).
REQ-002 Parameter: FILTER_CYCLES, default 4, consecutive identical samples required to accept a line state (1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 A  input  NUM_TRIOS  wire A LP level, bit i = trio i.
REQ-006 B  input  NUM_TRIOS  wire B LP level, bit i = trio i.
REQ-007 C  input  NUM_TRIOS  wire C LP level, bit i = trio i.
REQ-008 dec_en  input  1  decoder enable, common to all trios.
REQ-009 ctrl_state  output  2*NUM_TRIOS  accepted code of trio i in bits [2i+1:2i].
REQ-010 ctrl_valid  output  NUM_TRIOS  1 = accepted line state of trio i is a legal code.
REQ-011 hs_entry  output  NUM_TRIOS  one-cycle pulse: HS entry sequence completed.
REQ-012 esc_entry  output  NUM_TRIOS  one-cycle pulse: escape entry sequence completed.
REQ-013 seq_err  output  NUM_TRIOS  one-cycle pulse: illegal sequence or stable illegal line state.
REQ-014 err_cnt  output  8*NUM_TRIOS  per-trio seq_err count, present only with RX_CTRL_ERR_CNT_EN.

Function
REQ-015 Line state {A,B,C} decodes: 111->00 STOP, 001->01 HS_RQST, 000->10 BRIDGE, 100->11 LP_RQST; all other values illegal.
REQ-016 Each trio keeps previous sample and 4-bit stable counter; counter increments (saturating at FILTER_CYCLES) when sample equals previous sample, else loads 1.
REQ-017 A line state is accepted on the edge where its counter reaches FILTER_CYCLES; ctrl_state/ctrl_valid update on that edge (FILTER_CYCLES=1 gives one-cycle registered decode).
REQ-018 Legal accepted state: ctrl_state = code, ctrl_valid = 1; illegal accepted state: ctrl_state holds, ctrl_valid = 0.
REQ-019 Line pulses shorter than FILTER_CYCLES samples are ignored: no ctrl_state change, no pulse.
REQ-020 Accept event = acceptance of a legal code differing from the previously accepted code; FSM advances only on accept events.
REQ-021 Per-trio FSM states IDLE, STOP, HSRQ, LPRQ; IDLE: STOP->STOP, other codes stay IDLE without error.
REQ-022 STOP: HS_RQST->HSRQ; LP_RQST->LPRQ; BRIDGE->IDLE with seq_err.
REQ-023 HSRQ: BRIDGE->IDLE with hs_entry; STOP->STOP (abort, no error); LP_RQST->IDLE with seq_err.
REQ-024 LPRQ: BRIDGE->IDLE with esc_entry; STOP->STOP (abort, no error); HS_RQST->IDLE with seq_err.
REQ-025 Illegal line state accepted while FSM not IDLE: seq_err, FSM->IDLE; in IDLE no error.
REQ-026 hs_entry/esc_entry/seq_err register on the accepting edge, coincident with ctrl_state update, high exactly one cycle; at most one per trio per cycle.
REQ-027 Trios are fully independent; simultaneous events on several trios all reported in same cycle.
REQ-028 dec_en low: counters, samples, FSMs forced to reset values, all outputs except err_cnt at 0; err_cnt holds.
REQ-029 dec_en rising: filtering restarts from empty; first accept needs FILTER_CYCLES samples.

Reset
REQ-030 rst high at an edge: ctrl_state=0, ctrl_valid=0, pulses=0, counters=0, samples=0, FSMs=IDLE, err_cnt=0; rst overrides dec_en.
REQ-031 Reset mid-sequence aborts without any pulse; decoding resumes the edge after rst deasserts.

Configuration
REQ-032 Macro RX_CTRL_ERR_CNT_EN defined: err_cnt port present; per-trio 8-bit counter increments on each seq_err, saturates at 255, cleared only by rst.
REQ-033 Macro undefined: err_cnt port and counters absent; all other behaviour identical.

Verification (NUM_TRIOS=2, FILTER_CYCLES=4, dec_en=1 unless stated)
REQ-034 Trio0 111x4 ->001x4 ->000x4 -> ctrl_state[1:0] 00,01,10 each on 4th sample; hs_entry[0] one pulse on 12th edge; trio1 idle, no pulses.
REQ-035 Trio1 111x4 ->100x4 ->000x4 -> esc_entry[1] one pulse coincident with ctrl_state[3:2]=10; hs_entry=0.
REQ-036 Trio0 STOP stable, 001 for 3 samples then 111 -> ctrl_state[1:0] stays 00, no pulses, FSM still STOP.
REQ-037 Trio0 111x4 ->010x4 -> ctrl_valid[0]=0, ctrl_state[1:0]=00, seq_err[0] pulse; err_cnt[7:0]=1 with macro; 256 repeats saturate at 255.
REQ-038 Trio0 in HSRQ, rst pulsed one cycle then 000x4 -> no hs_entry, outputs zero after rst, ctrl_state[1:0]=10, FSM IDLE.
REQ-039 Both trios STOP->HS_RQST->BRIDGE in lockstep -> hs_entry=2'b11 same cycle; dec_en low mid-sequence clears outputs, no pulse.
